// File: rtl/if_id_stage.sv
// IF/ID pipeline register: captures the fetched PC/instruction, flags AdEL on
// misaligned or out-of-range fetch addresses, and supports stall, flush and
// exception-entry squash. Optional stall counter enabled by IF_ID_STALL_CNT_EN.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic        exc_flush,
  input  logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  input  logic        bd_f,
  output logic [31:0] pc_d,
  output logic [31:0] instr_d,
  output logic [4:0]  exc_code_d,
  output logic        bd_d,
  output logic        valid_d,
  output logic [15:0] stall_cnt
);

  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [4:0]  exc_code_q;
  logic        bd_q;
  logic        valid_q;

  logic fetch_adel;
  logic load_any;

  // Flow control: en=1 means the stage accepts the F-side word on this edge;
  // en=0 freezes every output. exc_flush overrides the stall so exception
  // entry can always squash the stage.
  assign fetch_adel = (pc_f[1:0] != 2'b00) || (pc_f < IM_LO) || (pc_f > IM_HI);
  assign load_any   = exc_flush || en;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      exc_code_q <= 5'd0;
      bd_q       <= 1'b0;
      valid_q    <= 1'b0;
    end else if (exc_flush) begin
      pc_q       <= pc_f;
      instr_q    <= 32'h0;
      exc_code_q <= 5'd0;
      bd_q       <= 1'b0;
      valid_q    <= 1'b0;
    end else if (!en) begin
      pc_q       <= pc_q;
      instr_q    <= instr_q;
      exc_code_q <= exc_code_q;
      bd_q       <= bd_q;
      valid_q    <= valid_q;
    end else if (flush) begin
      // PC survives the squash so a later exception can still report EPC.
      pc_q       <= pc_f;
      instr_q    <= 32'h0;
      exc_code_q <= 5'd0;
      bd_q       <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_f;
      instr_q    <= fetch_adel ? 32'h0 : instr_f;
      exc_code_q <= fetch_adel ? EXC_ADEL : 5'd0;
      bd_q       <= bd_f;
      valid_q    <= 1'b1;
    end
  end

  assign pc_d       = pc_q;
  assign instr_d    = instr_q;
  assign exc_code_d = exc_code_q;
  assign bd_d       = bd_q;
  assign valid_d    = valid_q;

`ifdef IF_ID_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || load_any) begin
      stall_cnt_q <= 16'h0;
    end else if (stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_load_any;
  assign unused_load_any = load_any;
  assign stall_cnt       = 16'h0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, load, AdEL boundaries, stall/flush,
// exception squash and reset priority. Stall count expectations follow IF_ID_STALL_CNT_EN.
module tb_if_id_stage;

`ifdef IF_ID_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        en;
  logic        flush;
  logic        exc_flush;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic        bd_f;
  logic [31:0] pc_d;
  logic [31:0] instr_d;
  logic [4:0]  exc_code_d;
  logic        bd_d;
  logic        valid_d;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  if_id_stage dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .flush      (flush),
    .exc_flush  (exc_flush),
    .pc_f       (pc_f),
    .instr_f    (instr_f),
    .bd_f       (bd_f),
    .pc_d       (pc_d),
    .instr_d    (instr_d),
    .exc_code_d (exc_code_d),
    .bd_d       (bd_d),
    .valid_d    (valid_d),
    .stall_cnt  (stall_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // packed view of the pipeline outputs: {pc, instr, exc, bd, valid}
  logic [70:0] got;
  assign got = {pc_d, instr_d, exc_code_d, bd_d, valid_d};

  task automatic drive(input logic r, input logic e, input logic fl, input logic xf,
                       input logic [31:0] pc, input logic [31:0] ins, input logic bd);
    reset = r; en = e; flush = fl; exc_flush = xf;
    pc_f = pc; instr_f = ins; bd_f = bd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [70:0] exp;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_5550, 32'hFFFF_FFFF, 1'b1);
    step();
    exp = {32'h0000_3000, 32'h0, 5'd0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL reset_state: got %h expected %h", got, exp);
    end
    checks++;
    if (stall_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_stall_cnt: got %h expected 0000", stall_cnt);
    end
  endtask

  task automatic test_load();
    logic [70:0] exp;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3004, 32'h2408_0001, 1'b1);
    step();
    exp = {32'h0000_3004, 32'h2408_0001, 5'd0, 1'b1, 1'b1};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL load_basic: got %h expected %h", got, exp);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3008, 32'hA5A5_5A5A, 1'b0);
    step();
    exp = {32'h0000_3008, 32'hA5A5_5A5A, 5'd0, 1'b0, 1'b1};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL load_back_to_back: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_adel();
    logic [31:0] pcs  [6] = '{32'h0000_3002, 32'h0000_7000, 32'h0000_6FFC,
                              32'h0000_3000, 32'h0000_2FFC, 32'h0000_3001};
    logic [4:0]  excs [6] = '{5'd4, 5'd4, 5'd0, 5'd0, 5'd4, 5'd4};
    logic [70:0] exp;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, pcs[i], 32'h1357_0000 + 32'(i), 1'b0);
      step();
      exp = {pcs[i], (excs[i] != 5'd0) ? 32'h0 : 32'h1357_0000 + 32'(i), excs[i], 1'b0, 1'b1};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL adel_vec%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_stall_flush();
    logic [70:0] held;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3010, 32'h1111_1111, 1'b0);
    step();
    held = {32'h0000_3010, 32'h1111_1111, 5'd0, 1'b0, 1'b1};
    checks++;
    if (got !== held) begin
      errors++; $display("FAIL stall_preload: got %h expected %h", got, held);
    end
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_5000, 32'hDEAD_BEEF, 1'b1);
      step();
      checks++;
      if (got !== held) begin
        errors++; $display("FAIL stall_hold%0d: got %h expected %h", i, got, held);
      end
      checks++;
      if (stall_cnt !== (CNT_ON ? 16'(i) : 16'h0)) begin
        errors++; $display("FAIL stall_cnt%0d: got %h expected %h", i, stall_cnt,
                           CNT_ON ? 16'(i) : 16'h0);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3014, 32'h2222_2222, 1'b0);
    step();
    checks++;
    if (got !== {32'h0000_3014, 32'h2222_2222, 5'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL stall_release: got %h expected %h", got,
                         {32'h0000_3014, 32'h2222_2222, 5'd0, 1'b0, 1'b1});
    end
    checks++;
    if (stall_cnt !== 16'h0) begin
      errors++; $display("FAIL stall_cnt_clear: got %h expected 0000", stall_cnt);
    end
  endtask

  task automatic test_flush();
    logic [70:0] exp;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_3020, 32'h0000_1234, 1'b1);
    step();
    exp = {32'h0000_3020, 32'h0, 5'd0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL flush_bubble: got %h expected %h", got, exp);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_3001, 32'h0000_5678, 1'b1);
    step();
    exp = {32'h0000_3001, 32'h0, 5'd0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL flush_no_adel: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_adel_hold();
    logic [70:0] exp;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_7000, 32'h9999_9999, 1'b1);
    step();
    exp = {32'h0000_7000, 32'h0, 5'd4, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3030, 32'h7777_7777, 1'b0);
      step();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL adel_hold%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_exc_flush();
    logic [70:0] exp;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4180, 32'h3333_3333, 1'b1);
    step();
    exp = {32'h0000_4180, 32'h0, 5'd0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL exc_flush_stalled: got %h expected %h", got, exp);
    end
    checks++;
    if (stall_cnt !== 16'h0) begin
      errors++; $display("FAIL exc_flush_cnt: got %h expected 0000", stall_cnt);
    end
  endtask

  task automatic test_reset_priority();
    logic [70:0] exp;
    exp = {32'h0000_3000, 32'h0, 5'd0, 1'b0, 1'b0};
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_4180, 32'h4444_4444, 1'b1);
    step();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL reset_over_exc: got %h expected %h", got, exp);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3040, 32'h5555_5555, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3044, 32'h6666_6666, 1'b0);
    step();
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_3044, 32'h6666_6666, 1'b0);
    step();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL reset_mid_stall: got %h expected %h", got, exp);
    end
    checks++;
    if (stall_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_mid_stall_cnt: got %h expected 0000", stall_cnt);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3048, 32'h7777_0000, 1'b1);
    step();
    exp = {32'h0000_3048, 32'h7777_0000, 5'd0, 1'b1, 1'b1};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL resume_after_reset: got %h expected %h", got, exp);
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    test_reset();
    test_load();
    test_adel();
    test_stall_flush();
    test_flush();
    test_adel_hold();
    test_exc_flush();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, PC value presented by pc_d after reset.
REQ-002 SHALL have parameter IM_LO, default 32'h0000_3000, lowest legal fetch address.
REQ-003 SHALL have parameter IM_HI, default 32'h0000_6FFC, highest legal fetch address.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en  input  1  1 = load from F; 0 = hold (stall).
REQ-007 SHALL have port flush  input  1  replace incoming F instruction with a bubble (squash).
REQ-008 SHALL have port exc_flush  input  1  exception/interrupt entry; forces a bubble regardless of en.
REQ-009 SHALL have port pc_f  input  32  PC of the instruction being fetched.
REQ-010 SHALL have port instr_f  input  32  fetched instruction word.
REQ-011 SHALL have port bd_f  input  1  F instruction sits in a branch delay slot.
REQ-012 SHALL have outputs pc_d (32), instr_d (32), exc_code_d (5), bd_d (1), valid_d (1), stall_cnt (16), all registered.

Function
REQ-013 SHALL evaluate, per posedge, in strict priority: reset > exc_flush > (en==0 hold) > flush > load.
REQ-014 SHALL on exc_flush=1 load a bubble even when en=0: instr_d=0, valid_d=0, exc_code_d=0, bd_d=0, pc_d=pc_f.
REQ-015 SHALL on en=0 (no reset, no exc_flush) hold every output unchanged; flush is ignored that cycle.
REQ-016 SHALL on en=1, flush=1 load a bubble as in REQ-014 except pc_d=pc_f retained for EPC use.
REQ-017 SHALL on en=1, flush=0 load pc_d=pc_f, bd_d=bd_f, valid_d=1, one-cycle latency F->D.
REQ-018 SHALL on load flag AdEL (exc_code_d=5'd4) when pc_f[1:0]!=0 or pc_f<IM_LO or pc_f>IM_HI (unsigned compare).
REQ-019 SHALL on AdEL load instr_d=32'h0 (nop) instead of instr_f; otherwise instr_d=instr_f, exc_code_d=0.
REQ-020 SHALL treat boundaries inclusively: pc_f=IM_LO and pc_f=IM_HI legal; IM_HI+4 is AdEL.
REQ-021 SHALL keep a captured AdEL (exc_code_d, pc_d, bd_d) stable through any number of stall cycles.

Reset
REQ-022 SHALL on reset=1 set pc_d=RESET_PC, instr_d=0, exc_code_d=0, bd_d=0, valid_d=0, stall_cnt=0, overriding all other inputs.
REQ-023 SHALL, on reset asserted mid-stall or mid-flush, reach the REQ-022 state at that same edge and resume normal priority on the first edge with reset=0.

Configuration
REQ-024 SHALL, with macro IF_ID_STALL_CNT_EN defined, drive stall_cnt as count of consecutive edges with en=0 and no exc_flush, saturating at 16'hFFFF.
REQ-025 SHALL, with IF_ID_STALL_CNT_EN defined, clear stall_cnt to 0 on any edge that loads (REQ-014/016/017).
REQ-026 SHALL, without IF_ID_STALL_CNT_EN, keep port stall_cnt present and tied to 16'h0, with no counter logic instantiated.

Verification
REQ-027 SHALL cover: reset=1 one edge -> pc_d=0x3000, valid_d=0, instr_d=0, stall_cnt=0.
REQ-028 SHALL cover: en=1, pc_f=0x3004, instr_f=0x24080001, bd_f=1 -> next edge pc_d=0x3004, instr_d=0x24080001, bd_d=1, valid_d=1, exc_code_d=0.
REQ-029 SHALL cover: en=1, pc_f=0x3002, then pc_f=0x7000, then pc_f=0x6FFC -> exc_code_d=4, instr_d=0; exc_code_d=4; exc_code_d=0.
REQ-030 SHALL cover: en=0 for 3 edges with flush=1 -> outputs unchanged, stall_cnt=3 (macro on) / 0 (macro off); then en=1 -> stall_cnt=0.
REQ-031 SHALL cover: en=0 and exc_flush=1, pc_f=0x4180 -> valid_d=0, instr_d=0, pc_d=0x4180 at next edge.
REQ-032 SHALL cover: reset=1 together with exc_flush=1 and en=1 -> REQ-022 state, pc_d=0x3000.
